mem_arbiter: RTL

Round-robin arbiter that shares one single-port synchronous RAM between three CPU-side requesters: port 0 instruction fetch, port 1 data load/store, port 2 program loader/debug. It sits between the `cpu` core and the memory. It accepts at most one access per cycle and registers the winning access onto the RAM bus. It returns read data, tagged with `rvalid`, to the port that issued the read.

---
 rtl/mem_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter: three-port round-robin arbiter in front of one sync RAM.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          req,
  input  logic [2:0]          we,
  input  logic [3*ADDR_W-1:0] addr,
  input  logic [3*DATA_W-1:0] wdata,
  output logic [2:0]          gnt,
  output logic [2:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  logic [1:0]        rr_q, rr_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        owner_q, owner_d;
  logic [2:0]        rvalid_q, rvalid_d;

  logic [1:0] start;
  logic [1:0] cand0, cand1, cand2;
  logic [1:0] win;
  logic       accept;

  // Search order is rr, rr+1, rr+2 (mod 3); an out-of-range pointer acts as 0.
  always_comb begin
    start = (rr_q == 2'd3) ? 2'd0 : rr_q;
    cand0 = start;
    cand1 = (start == 2'd2) ? 2'd0 : start + 2'd1;
    cand2 = (start == 2'd0) ? 2'd2 : start - 2'd1;
    win   = cand0;
    if (req[cand0])      win = cand0;
    else if (req[cand1]) win = cand1;
    else if (req[cand2]) win = cand2;
    accept = (|req) && !rst;
    gnt    = accept ? (3'b001 << win) : 3'b000;
  end

  always_comb begin
    rr_d        = rr_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    owner_d     = owner_q;
    if (accept) begin
      mem_en_d    = 1'b1;
      mem_we_d    = we[win];
      mem_addr_d  = addr[int'(win)*ADDR_W +: ADDR_W];
      mem_wdata_d = wdata[int'(win)*DATA_W +: DATA_W];
      owner_d     = win;
      rr_d        = (win == 2'd2) ? 2'd0 : win + 2'd1;
    end
    rvalid_d = (mem_en_q && !mem_we_q) ? (3'b001 << owner_q) : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= 2'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      owner_q     <= 2'd0;
      rvalid_q    <= 3'b000;
    end else begin
      rr_q        <= rr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      owner_q     <= owner_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rvalid    = rvalid_q;
  assign rdata     = mem_rdata;

endmodule
`default_nettype wire
